// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store FSM states and width constants.
package cpu_pkg;

   // Default datapath / address width in bits.
   localparam int unsigned DataWDef    = 64;
   // Default log2 of access size in bytes (8-byte LDUR/STUR).
   localparam int unsigned AlignLg2Def = 3;
   // Architectural register number width.
   localparam int unsigned RegW        = 5;

   // Load/store unit FSM states.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StResp = 2'd2
   } ldst_state_e;

endpackage : cpu_pkg

// File: rtl/ldst_agu.sv
// Address generation: base + sign-extended offset, carry discarded, plus a
// misalignment flag for the configured access size.
module ldst_agu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W    = DataWDef,
   parameter int unsigned ALIGN_LG2 = AlignLg2Def
) (
   input  logic [DATA_W-1:0] base,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] addr,
   output logic              misaligned
);

   // Modular add; the carry out simply falls off the top.
   assign addr = base + imm;

   // Byte-sized accesses can never be misaligned.
   if (ALIGN_LG2 == 0) begin : g_byte
      assign misaligned = 1'b0;
   end else begin : g_chk
      assign misaligned = |addr[ALIGN_LG2-1:0];
   end

endmodule : ldst_agu

// File: rtl/ldst_unit.sv
// Single-outstanding load/store unit: accepts one LDUR/STUR from EX, checks
// alignment, runs a req/ack handshake to data memory and returns load data.
module ldst_unit
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W    = DataWDef,
   parameter int unsigned ALIGN_LG2 = AlignLg2Def
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ex_valid,
   input  logic              ex_is_load,
   input  logic [DATA_W-1:0] ex_base,
   input  logic [DATA_W-1:0] ex_imm,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [RegW-1:0]   ex_rd,
   input  logic              flush,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [RegW-1:0]   wb_rd,
   output logic              align_fault
);

   ldst_state_e       state_q, state_d;
   logic [DATA_W-1:0] addr_q, wdata_q, rdata_q, wb_data_q;
   logic [RegW-1:0]   rd_q, wb_rd_q;
   logic              is_load_q, killed_q, fault_q;
   logic [DATA_W-1:0] agu_addr;
   logic              agu_misaligned;
   logic              accept;

   ldst_agu #(
      .DATA_W    (DATA_W),
      .ALIGN_LG2 (ALIGN_LG2)
   ) u_agu (
      .base       (ex_base),
      .imm        (ex_imm),
      .addr       (agu_addr),
      .misaligned (agu_misaligned)
   );

   assign accept = (state_q == StIdle) && ex_valid && !flush;

   // Registered request fields stay on the bus unchanged until ack.
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign align_fault = fault_q;

   // Writeback ports show fresh data only while wb_valid, otherwise the last
   // value actually written back (a killed load must not disturb them).
   assign wb_data = wb_valid ? rdata_q : wb_data_q;
   assign wb_rd   = wb_valid ? rd_q    : wb_rd_q;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      wb_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            stall = ex_valid;
            if (accept && !agu_misaligned) begin
               state_d = StReq;
            end
         end
         StReq: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            mem_we  = !is_load_q;
            if (mem_ack) begin
               state_d = StResp;
            end
         end
         StResp: begin
            stall    = 1'b1;
            // Flush arriving in this very cycle still cancels writeback.
            wb_valid = is_load_q && !killed_q && !flush;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Operation latch, kill tracking, load data capture and writeback hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         is_load_q <= 1'b0;
         killed_q  <= 1'b0;
         fault_q   <= 1'b0;
         rdata_q   <= '0;
         wb_data_q <= '0;
         wb_rd_q   <= '0;
      end else begin
         fault_q <= accept && agu_misaligned;
         if (accept) begin
            addr_q    <= agu_addr;
            wdata_q   <= ex_wdata;
            rd_q      <= ex_rd;
            is_load_q <= ex_is_load;
            killed_q  <= 1'b0;
         end else if ((state_q == StReq) && flush) begin
            // Bus cycle keeps running; only the writeback is cancelled.
            killed_q <= 1'b1;
         end
         if ((state_q == StReq) && mem_ack) begin
            rdata_q <= mem_rdata;
         end
         if (wb_valid) begin
            wb_data_q <= rdata_q;
            wb_rd_q   <= rd_q;
         end
      end
   end

endmodule : ldst_unit

// File: tb/tb_ldst_unit.sv
// Directed self-checking bench for ldst_unit.
module tb_ldst_unit;

   logic        clk;
   logic        reset_n;
   logic        ex_valid;
   logic        ex_is_load;
   logic [63:0] ex_base;
   logic [63:0] ex_imm;
   logic [63:0] ex_wdata;
   logic [4:0]  ex_rd;
   logic        flush;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic        wb_valid;
   logic [63:0] wb_data;
   logic [4:0]  wb_rd;
   logic        align_fault;

   int tests;
   int fails;

   ldst_unit #(
      .DATA_W    (64),
      .ALIGN_LG2 (3)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ex_valid    (ex_valid),
      .ex_is_load  (ex_is_load),
      .ex_base     (ex_base),
      .ex_imm      (ex_imm),
      .ex_wdata    (ex_wdata),
      .ex_rd       (ex_rd),
      .flush       (flush),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .wb_valid    (wb_valid),
      .wb_data     (wb_data),
      .wb_rd       (wb_rd),
      .align_fault (align_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   task automatic issue(input logic ld, input logic [63:0] b, input logic [63:0] i,
                        input logic [63:0] wd, input logic [4:0] rd);
      ex_valid   = 1'b1;
      ex_is_load = ld;
      ex_base    = b;
      ex_imm     = i;
      ex_wdata   = wd;
      ex_rd      = rd;
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      reset_n    = 1'b0;
      ex_valid   = 1'b0;
      ex_is_load = 1'b0;
      ex_base    = '0;
      ex_imm     = '0;
      ex_wdata   = '0;
      ex_rd      = '0;
      flush      = 1'b0;
      mem_ack    = 1'b0;
      mem_rdata  = '0;

      // Reset values
      #12;
      chk("rst_stall", stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_align_fault", align_fault, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", wb_rd, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Aligned load, ack in first REQ cycle
      issue(1'b1, 64'h1000, 64'h10, 64'h0, 5'd7);
      settle();
      chk("ld_stall_comb", stall, 1);
      chk("ld_idle_noreq", mem_req, 0);
      tick();
      ex_valid = 1'b0;
      settle();
      chk("ld_req", mem_req, 1);
      chk("ld_we", mem_we, 0);
      chk("ld_addr", mem_addr, 64'h1010);
      chk("ld_req_stall", stall, 1);
      chk("ld_req_nowb", wb_valid, 0);
      mem_ack   = 1'b1;
      mem_rdata = 64'hDEAD_BEEF_0123_4567;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 64'h0;
      settle();
      chk("ld_wb_valid", wb_valid, 1);
      chk("ld_wb_data", wb_data, 64'hDEAD_BEEF_0123_4567);
      chk("ld_wb_rd", wb_rd, 7);
      chk("ld_resp_noreq", mem_req, 0);
      chk("ld_resp_stall", stall, 1);
      tick();
      settle();
      chk("ld_done_wb", wb_valid, 0);
      chk("ld_done_stall", stall, 0);
      chk("ld_hold_data", wb_data, 64'hDEAD_BEEF_0123_4567);
      chk("ld_hold_rd", wb_rd, 7);

      // Store, ack in fourth REQ cycle, negative offset
      issue(1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1122_3344_5566_7788, 5'd1);
      tick();
      ex_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("st_req", mem_req, 1);
         chk("st_we", mem_we, 1);
         chk("st_addr", mem_addr, 64'h1FF8);
         chk("st_wdata", mem_wdata, 64'h1122_3344_5566_7788);
         chk("st_stall", stall, 1);
         chk("st_nowb", wb_valid, 0);
         if (k == 3) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      settle();
      chk("st_resp_nowb", wb_valid, 0);
      chk("st_resp_stall", stall, 1);
      chk("st_resp_noreq", mem_req, 0);
      tick();
      settle();
      chk("st_done_stall", stall, 0);

      // Address wrap-around
      issue(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h0, 5'd3);
      tick();
      ex_valid = 1'b0;
      settle();
      chk("wrap_addr", mem_addr, 64'h8);
      chk("wrap_req", mem_req, 1);
      mem_ack   = 1'b1;
      mem_rdata = 64'h55;
      tick();
      mem_ack = 1'b0;
      settle();
      chk("wrap_wb_valid", wb_valid, 1);
      chk("wrap_wb_data", wb_data, 64'h55);
      chk("wrap_wb_rd", wb_rd, 3);
      tick();

      // Stray ack in IDLE is ignored
      mem_ack = 1'b1;
      settle();
      chk("stray_noreq", mem_req, 0);
      tick();
      mem_ack = 1'b0;
      settle();
      chk("stray_nowb", wb_valid, 0);
      chk("stray_stall", stall, 0);

      // Misaligned access
      issue(1'b1, 64'h1003, 64'h0, 64'h0, 5'd9);
      settle();
      chk("mis_stall_comb", stall, 1);
      tick();
      ex_valid = 1'b0;
      settle();
      chk("mis_fault", align_fault, 1);
      chk("mis_noreq", mem_req, 0);
      chk("mis_idle_stall", stall, 0);
      tick();
      settle();
      chk("mis_fault_pulse", align_fault, 0);
      chk("mis_noreq2", mem_req, 0);

      // Flush in IDLE blocks acceptance
      issue(1'b1, 64'h1000, 64'h0, 64'h0, 5'd2);
      flush = 1'b1;
      tick();
      ex_valid = 1'b0;
      flush    = 1'b0;
      settle();
      chk("fl_idle_noreq", mem_req, 0);
      chk("fl_idle_nofault", align_fault, 0);

      // Flush during REQ on a load
      issue(1'b1, 64'h3000, 64'h8, 64'h0, 5'd12);
      tick();
      ex_valid = 1'b0;
      settle();
      chk("fl_req_req", mem_req, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      settle();
      chk("fl_req_held", mem_req, 1);
      chk("fl_req_addr", mem_addr, 64'h3008);
      mem_ack   = 1'b1;
      mem_rdata = 64'h77;
      tick();
      mem_ack = 1'b0;
      settle();
      chk("fl_req_nowb", wb_valid, 0);
      chk("fl_req_hold_data", wb_data, 64'h55);
      chk("fl_req_hold_rd", wb_rd, 3);
      tick();
      settle();
      chk("fl_req_nowb2", wb_valid, 0);
      chk("fl_req_stall", stall, 0);

      // Flush in RESP suppresses writeback that cycle
      issue(1'b1, 64'h4000, 64'h0, 64'h0, 5'd4);
      tick();
      ex_valid  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 64'h99;
      tick();
      mem_ack = 1'b0;
      flush   = 1'b1;
      settle();
      chk("fl_resp_nowb", wb_valid, 0);
      chk("fl_resp_hold_data", wb_data, 64'h55);
      tick();
      flush = 1'b0;
      settle();
      chk("fl_resp_stall", stall, 0);

      // Reset mid-REQ abandons the request
      issue(1'b1, 64'h5000, 64'h20, 64'h0, 5'd5);
      tick();
      ex_valid = 1'b0;
      settle();
      chk("rr_req", mem_req, 1);
      reset_n = 1'b0;
      settle();
      chk("rr_req_drop", mem_req, 0);
      chk("rr_stall", stall, 0);
      chk("rr_addr", mem_addr, 0);
      tick();
      reset_n = 1'b1;
      settle();
      chk("rr_nowb", wb_valid, 0);
      tick();
      settle();
      chk("rr_nowb2", wb_valid, 0);
      chk("rr_idle", mem_req, 0);

      // Normal load after reset
      issue(1'b1, 64'h6000, 64'h18, 64'h0, 5'd31);
      tick();
      ex_valid = 1'b0;
      settle();
      chk("post_addr", mem_addr, 64'h6018);
      mem_ack   = 1'b1;
      mem_rdata = 64'hCAFE;
      tick();
      mem_ack = 1'b0;
      settle();
      chk("post_wb_valid", wb_valid, 1);
      chk("post_wb_data", wb_data, 64'hCAFE);
      chk("post_wb_rd", wb_rd, 31);
      tick();
      settle();
      chk("post_done", wb_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_ldst_unit
